// File: rtl/multu_seq_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multu_seq_unit_if
// Purpose  : Issue-side bundle between an issuing stage and the sequential
//            unsigned multiplier.
// Signals  : start      - operation request from the issuer
//            src1       - multiplicand
//            src2       - multiplier
//            busy       - multiplier is not idle
//            done       - one-cycle pulse when the product is valid
//            product_hi - upper 32 bits of the 64-bit product
//            product_lo - lower 32 bits of the 64-bit product
// Modports : master - the issuing stage
//            slave  - the multiplier
// Revision : 1.0 - initial release
// ============================================================================
interface multu_seq_unit_if;
    logic        start;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    modport master (
        output start, src1, src2,
        input  busy, done, product_hi, product_lo
    );

    modport slave (
        input  start, src1, src2,
        output busy, done, product_hi, product_lo
    );
endinterface
`default_nettype wire

// File: rtl/multu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : multu_seq_unit
// Purpose  : Sequential 32x32 unsigned shift-add multiplier controller. It
//            drives an external combinational ALU with one partial-product
//            add per cycle and folds the ALU sum/carry back into a 64-bit
//            {hi,lo} shift register.
// Ports    : clk        - clock, all state updates on the rising edge
//            rst        - synchronous active-high reset
//            bus        - issue-side start/busy/done/operand/product bundle
//            alu_src1   - ALU operand A (current upper partial product)
//            alu_src2   - ALU operand B (multiplicand or zero)
//            alu_funct  - ALU function code, always unsigned add
//            alu_result - ALU 32-bit sum
//            alu_carry  - ALU carry-out of the add
// Revision : 1.0 - initial release
// ============================================================================
module multu_seq_unit #(
    parameter logic [5:0] ADDU_FUNCT = 6'b001001,
    parameter int         ITERATIONS = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    multu_seq_unit_if.slave  bus,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic [5:0]       alu_funct,
    input  wire logic [31:0] alu_result,
    input  wire logic        alu_carry
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [4:0] c_LAST_CNT = 5'(ITERATIONS - 1);

    logic [1:0]  r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;

    // The low bit of lo is always the multiplier bit for the current step,
    // because lo shifts right once per step while product bits fill in at
    // the top.
    assign alu_src1  = r_hi;
    assign alu_src2  = r_lo[0] ? r_mcand : 32'h0;
    assign alu_funct = ADDU_FUNCT;

    assign bus.busy       = (r_state != c_IDLE);
    assign bus.done       = (r_state == c_DONE);
    assign bus.product_hi = r_hi;
    assign bus.product_lo = r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_mcand <= 32'h0;
            r_hi    <= 32'h0;
            r_lo    <= 32'h0;
            r_cnt   <= 5'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_mcand <= bus.src1;
                        r_hi    <= 32'h0;
                        r_lo    <= bus.src2;
                        r_cnt   <= 5'd0;
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    // The carry is the 33rd sum bit; shifting the whole
                    // 33-bit sum right by one keeps it inside hi.
                    r_hi  <= {alu_carry, alu_result[31:1]};
                    r_lo  <= {alu_result[0], r_lo[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST_CNT) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multu_seq_unit
// Purpose  : Self-checking bench for multu_seq_unit. A combinational ALU
//            model closes the loop; a cycle-count/arithmetic reference model
//            is compared against the DUT every cycle, and directed operations
//            are pinned with hand-computed products and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multu_seq_unit;

    logic        clk;
    logic        rst;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [5:0]  alu_funct;
    logic [31:0] alu_result;
    logic        alu_carry;

    multu_seq_unit_if bus_if ();

    multu_seq_unit dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_funct  (alu_funct),
        .alu_result (alu_result),
        .alu_carry  (alu_carry)
    );

    // Downstream ALU: unsigned add with carry-out.
    assign {alu_carry, alu_result} = {1'b0, alu_src1} + {1'b0, alu_src2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: m_k counts cycles since the accepted start
    // (0 = idle, 1..32 = calculating, 33 = done cycle).
    // ------------------------------------------------------------------
    int          cyc     = 0;
    logic        m_valid = 1'b0;
    int          m_k     = 0;
    logic [31:0] m_a     = 32'h0;
    logic [31:0] m_b     = 32'h0;
    logic [63:0] m_prod  = 64'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_valid <= 1'b1;
            m_k     <= 0;
            m_prod  <= 64'h0;
        end else if (m_k == 0) begin
            if (bus_if.start) begin
                m_k <= 1;
                m_a <= bus_if.src1;
                m_b <= bus_if.src2;
            end
        end else if (m_k == 33) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
            if (m_k == 32) begin
                m_prod <= {32'h0, m_a} * {32'h0, m_b};
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 64'(bus_if.busy), 64'(m_k != 0));
            chk("done", 64'(bus_if.done), 64'(m_k == 33));
            chk("alu_funct", 64'(alu_funct), 64'(6'b001001));
            if (m_k == 0 || m_k == 33) begin
                chk("product", {bus_if.product_hi, bus_if.product_lo}, m_prod);
            end
            if (m_k == 0) begin
                chk("alu_src1_idle", 64'(alu_src1), 64'(m_prod[63:32]));
            end
            if (m_k == 1) begin
                chk("alu_src1_first", 64'(alu_src1), 64'h0);
                chk("alu_src2_first", 64'(alu_src2), 64'(m_b[0] ? m_a : 32'h0));
            end
            if (m_k >= 1 && m_k <= 32 && m_b == 32'h0) begin
                chk("alu_src2_zero", 64'(alu_src2), 64'h0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    int t0;

    // Drives a one-cycle start; returns in the first calculating cycle with
    // the operands scrambled so that late changes are exercised.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        bus_if.start = 1'b1;
        bus_if.src1  = a;
        bus_if.src2  = b;
        @(negedge clk);
        t0           = cyc;
        bus_if.start = 1'b0;
        bus_if.src1  = $urandom;
        bus_if.src2  = $urandom;
    endtask

    // Waits for done; done is visible 32 edges after the start edge,
    // i.e. in the 33rd cycle after the start was sampled.
    task automatic wait_done(input logic [63:0] exp, input string name);
        int n;
        n = 0;
        while (bus_if.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        if (bus_if.done !== 1'b1) begin
            chk({name, "_done_timeout"}, 64'h0, 64'h1);
        end
        chk({name, "_latency"}, 64'(cyc - t0), 64'd32);
        chk({name, "_product"}, {bus_if.product_hi, bus_if.product_lo}, exp);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
        launch(a, b);
        wait_done(exp, name);
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.src1  = 32'h0;
        bus_if.src2  = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus_if.busy), 64'h0);
        chk("reset_done", 64'(bus_if.done), 64'h0);
        chk("reset_product", {bus_if.product_hi, bus_if.product_lo}, 64'h0);
        chk("reset_alu_src2", 64'(alu_src2), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'h1, 32'h2, 64'h0000_0000_0000_0002, "mul_1x2");
        run_op(32'h4, 32'h5, 64'h0000_0000_0000_0014, "mul_4x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mul_max");
        run_op(32'h1234_5678, 32'h0, 64'h0, "mul_x_by_0");
        run_op(32'h0, 32'hFFFF_FFFF, 64'h0, "mul_0_by_x");

        // A start pulse during the calculation must be ignored.
        launch(32'h5, 32'h6);
        repeat (5) @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.src1  = 32'h7;
        bus_if.src2  = 32'h9;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.src1  = 32'hDEAD_BEEF;
        bus_if.src2  = 32'h0BAD_F00D;
        wait_done(64'h0000_0000_0000_001E, "mul_5x6_ignored_start");
        @(negedge clk);
        run_op(32'h7, 32'h9, 64'h0000_0000_0000_003F, "mul_7x9");

        // Reset in the tenth calculating cycle discards the operation.
        launch(32'h0000_FFFF, 32'h3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_busy", 64'(bus_if.busy), 64'h0);
        chk("midreset_done", 64'(bus_if.done), 64'h0);
        chk("midreset_product", {bus_if.product_hi, bus_if.product_lo}, 64'h0);
        @(negedge clk);
        run_op(32'h3, 32'h3, 64'h0000_0000_0000_0009, "mul_3x3_after_reset");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
